// File: rtl/egg_timer_pkg.sv
// Shared definitions for the egg timer controller.
//   state_t    : controller FSM encoding (visible on the top-level 'state' port)
//   DIGIT_W    : width of one BCD digit
//   SEC_LIMIT  : highest seconds value (59); tens/ones limits derived from it
//   MMSS_W     : width of a packed {min_tens, min_ones, sec_tens, sec_ones} value
package egg_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ALARM = 2'd3
    } state_t;

    localparam int DIGIT_W   = 4;
    localparam int SEC_LIMIT = 59;
    localparam int MMSS_W    = 4 * DIGIT_W;

    localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = DIGIT_W'(SEC_LIMIT / 10);
    localparam logic [DIGIT_W-1:0] SEC_ONES_MAX = DIGIT_W'(SEC_LIMIT % 10);
    localparam logic [DIGIT_W-1:0] BCD_NINE     = DIGIT_W'(9);

endpackage

// File: rtl/egg_bcd_mmss.sv
// mm:ss time register held as four BCD digits.
// Parameters:
//   MAX_MIN : highest minute value reached by inc_min before wrapping to 00
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   clr                 : zero all digits (highest priority)
//   load, load_val      : load {mt, mo, st, so} from load_val
//   dec                 : subtract one second with borrow from minutes
//   inc_min             : step minutes 00..MAX_MIN, wrap to 00
//   inc_sec             : step seconds 00..59, wrap to 00, no carry into minutes
//   min_tens..sec_ones  : registered digits
//   zero                : time is 00:00
//   one_left            : time is 00:01 (the next dec reaches 00:00)
module egg_bcd_mmss
    import egg_timer_pkg::*;
#(
    parameter int MAX_MIN = 99
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic [MMSS_W-1:0] load_val,
    input  logic              dec,
    input  logic              inc_min,
    input  logic              inc_sec,
    output logic [3:0]        min_tens,
    output logic [3:0]        min_ones,
    output logic [3:0]        sec_tens,
    output logic [3:0]        sec_ones,
    output logic              zero,
    output logic              one_left
);

    localparam logic [DIGIT_W-1:0] MIN_TENS_MAX = DIGIT_W'(MAX_MIN / 10);
    localparam logic [DIGIT_W-1:0] MIN_ONES_MAX = DIGIT_W'(MAX_MIN % 10);

    logic [DIGIT_W-1:0] mt_q, mo_q, st_q, so_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mt_q <= '0;
            mo_q <= '0;
            st_q <= '0;
            so_q <= '0;
        end else if (clr) begin
            mt_q <= '0;
            mo_q <= '0;
            st_q <= '0;
            so_q <= '0;
        end else if (load) begin
            {mt_q, mo_q, st_q, so_q} <= load_val;
        end else if (dec) begin
            if (so_q != '0) begin
                so_q <= so_q - 4'd1;
            end else if (st_q != '0) begin
                st_q <= st_q - 4'd1;
                so_q <= BCD_NINE;
            end else if ((mt_q != '0) || (mo_q != '0)) begin
                // ss=00: borrow a minute, seconds restart at 59
                st_q <= SEC_TENS_MAX;
                so_q <= SEC_ONES_MAX;
                if (mo_q != '0) begin
                    mo_q <= mo_q - 4'd1;
                end else begin
                    mt_q <= mt_q - 4'd1;
                    mo_q <= BCD_NINE;
                end
            end
        end else if (inc_min) begin
            if ((mt_q == MIN_TENS_MAX) && (mo_q == MIN_ONES_MAX)) begin
                mt_q <= '0;
                mo_q <= '0;
            end else if (mo_q >= BCD_NINE) begin
                mt_q <= mt_q + 4'd1;
                mo_q <= '0;
            end else begin
                mo_q <= mo_q + 4'd1;
            end
        end else if (inc_sec) begin
            if ((st_q == SEC_TENS_MAX) && (so_q == SEC_ONES_MAX)) begin
                st_q <= '0;
                so_q <= '0;
            end else if (so_q >= BCD_NINE) begin
                st_q <= st_q + 4'd1;
                so_q <= '0;
            end else begin
                so_q <= so_q + 4'd1;
            end
        end
    end

    assign min_tens = mt_q;
    assign min_ones = mo_q;
    assign sec_tens = st_q;
    assign sec_ones = so_q;

    assign zero     = (mt_q == '0) && (mo_q == '0) && (st_q == '0) && (so_q == '0);
    assign one_left = (mt_q == '0) && (mo_q == '0) && (st_q == '0) && (so_q == 4'd1);

endmodule

// File: rtl/egg_timer_ctrl.sv
// Kitchen egg timer controller: set mm:ss with buttons, count down on the
// 1 Hz tick, raise an alarm for ALARM_SECS seconds, then reload the preset.
// Parameters:
//   MAX_MIN    : highest settable minute value (1..99)
//   ALARM_SECS : tick_1hz pulses the alarm stays asserted (1..255)
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   tick_1hz                       : one-clk pulse per second
//   btn_start_stop, btn_min_inc,
//   btn_sec_inc, btn_clear         : one-clk button pulses
//   min_tens..sec_ones             : registered BCD display digits
//   state                          : FSM state (IDLE=0 RUN=1 PAUSE=2 ALARM=3)
//   alarm                          : high only in ALARM
//   display_blank                  : display blanking request
// Build option: EGG_TIMER_BLINK_EN makes display_blank toggle on each tick
// in PAUSE and ALARM; without it display_blank is tied to 0.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | setting time with inc buttons; start_stop arms if != 00:00
// ST_RUN   | counting down one second per tick
// ST_PAUSE | countdown frozen, ticks ignored
// ST_ALARM | alarm asserted; ends after ALARM_SECS ticks or any button
module egg_timer_ctrl
    import egg_timer_pkg::*;
#(
    parameter int MAX_MIN    = 99,
    parameter int ALARM_SECS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       btn_start_stop,
    input  logic       btn_min_inc,
    input  logic       btn_sec_inc,
    input  logic       btn_clear,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [1:0] state,
    output logic       alarm,
    output logic       display_blank
);

    localparam logic [7:0] ALARM_LOAD = 8'(ALARM_SECS);

    state_t            state_q;
    logic              alarm_q;
    logic [7:0]        alarm_cnt_q;
    logic [MMSS_W-1:0] preset_q;

    logic act_clear, act_ss, act_min, act_sec, any_btn;
    logic alarm_done;
    logic t_clr, t_load, t_dec, t_inc_min, t_inc_sec;
    logic t_zero, t_one_left;

    // One button acts per cycle: clear > start_stop > min_inc > sec_inc.
    always_comb begin
        act_clear  = btn_clear;
        act_ss     = btn_start_stop & ~btn_clear;
        act_min    = btn_min_inc & ~btn_start_stop & ~btn_clear;
        act_sec    = btn_sec_inc & ~btn_min_inc & ~btn_start_stop & ~btn_clear;
        any_btn    = btn_clear | btn_start_stop | btn_min_inc | btn_sec_inc;
        // Down-counter terminal count: the tick that would take it to 0 ends the alarm.
        alarm_done = tick_1hz && (alarm_cnt_q <= 8'd1);

        t_clr     = 1'b0;
        t_load    = 1'b0;
        t_dec     = 1'b0;
        t_inc_min = 1'b0;
        t_inc_sec = 1'b0;
        case (state_q)
            ST_IDLE: begin
                t_clr     = act_clear;
                t_inc_min = act_min;
                t_inc_sec = act_sec;
            end
            ST_RUN: begin
                t_clr = act_clear;
                // start_stop does not block the tick; the decrement still happens.
                t_dec = tick_1hz & ~act_clear;
            end
            ST_PAUSE: t_clr  = act_clear;
            ST_ALARM: t_load = any_btn | alarm_done;
            default: ;
        endcase
    end

    egg_bcd_mmss #(
        .MAX_MIN (MAX_MIN)
    ) u_mmss (
        .clk      (clk),
        .rst      (rst),
        .clr      (t_clr),
        .load     (t_load),
        .load_val (preset_q),
        .dec      (t_dec),
        .inc_min  (t_inc_min),
        .inc_sec  (t_inc_sec),
        .min_tens (min_tens),
        .min_ones (min_ones),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .zero     (t_zero),
        .one_left (t_one_left)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            alarm_q     <= 1'b0;
            alarm_cnt_q <= '0;
            preset_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (act_clear) begin
                        preset_q <= '0;
                    end else if (act_ss && !t_zero) begin
                        preset_q <= {min_tens, min_ones, sec_tens, sec_ones};
                        state_q  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (act_clear) begin
                        preset_q <= '0;
                        state_q  <= ST_IDLE;
                    end else if (tick_1hz && t_one_left) begin
                        // Reaching 00:00 beats a simultaneous pause request.
                        state_q     <= ST_ALARM;
                        alarm_q     <= 1'b1;
                        alarm_cnt_q <= ALARM_LOAD;
                    end else if (act_ss) begin
                        state_q <= ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (act_clear) begin
                        preset_q <= '0;
                        state_q  <= ST_IDLE;
                    end else if (act_ss) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_ALARM: begin
                    if (any_btn || alarm_done) begin
                        state_q     <= ST_IDLE;
                        alarm_q     <= 1'b0;
                        alarm_cnt_q <= '0;
                    end else if (tick_1hz) begin
                        alarm_cnt_q <= alarm_cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    alarm_q <= 1'b0;
                end
            endcase
        end
    end

    assign state = state_q;
    assign alarm = alarm_q;

`ifdef EGG_TIMER_BLINK_EN
    logic blank_q;
    logic blank_clr, blank_tgl;

    // Blank is forced low whenever the next state is IDLE or RUN.
    always_comb begin
        blank_tgl = tick_1hz & ((state_q == ST_PAUSE) | (state_q == ST_ALARM));
        blank_clr = 1'b0;
        case (state_q)
            ST_IDLE:  blank_clr = 1'b1;
            ST_RUN:   blank_clr = act_clear | ~((tick_1hz & t_one_left) | act_ss);
            ST_PAUSE: blank_clr = act_clear | act_ss;
            ST_ALARM: blank_clr = t_load;
            default:  blank_clr = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blank_q <= 1'b0;
        end else if (blank_clr) begin
            blank_q <= 1'b0;
        end else if (blank_tgl) begin
            blank_q <= ~blank_q;
        end
    end

    assign display_blank = blank_q;
`else
    assign display_blank = 1'b0;
`endif

endmodule
